move_scheduler: RTL

- Frame-synchronous movement scheduler between the keyboard decoder and the pixel generator.
- Captures key-press edges from left/right/middle and queues them as commands in a small FIFO.
- Applies at most one queued command per video frame, on the vertical-sync tick, and sequences a multi-frame jump.
- Drives x_pos/y_pos so the sprite position changes only once per frame, never mid-frame.

---
 rtl/move_scheduler.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
// Frame-synchronous sprite movement scheduler: queues key-press commands and
// applies at most one per video frame on the vertical-sync tick, sequencing jumps.
module move_scheduler #(
    parameter int X_INIT      = 304,
    parameter int Y_INIT      = 400,
    parameter int X_MAX       = 639,
    parameter int SPR_W       = 32,
    parameter int STEP        = 8,
    parameter int JUMP_FRAMES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       middle,
    input  logic       v_sync,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic [7:0] counter,
    output logic       busy,
    output logic       fifo_full,
    output logic       dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(JUMP_FRAMES + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [FW-1:0] JF_C     = FW'(JUMP_FRAMES);
    localparam logic [FW-1:0] FR_ONE   = FW'(1);
    localparam logic [10:0]   X_STEP_C = 11'(STEP);
    localparam logic [10:0]   X_LIM_C  = 11'(X_MAX - SPR_W + 1);
    localparam logic [9:0]    X_INIT_C = 10'(X_INIT);
    localparam logic [8:0]    Y_STEP_C = 9'(STEP);
    localparam logic [8:0]    Y_INIT_C = 9'(Y_INIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LEFT   = 2'd0;
    localparam logic [1:0] CMD_RIGHT  = 2'd1;
    localparam logic [1:0] CMD_MIDDLE = 2'd2;

    logic [1:0]    vs_sync_q;
    logic          vs_prev_q;
    logic          tick_q;
    logic          tick_d;
    logic [2:0]    key_prev_q;
    logic [1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [1:0]    fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          dropped_q, dropped_d;

    logic [2:0]    edge_s;
    logic          push_req_s, push_ok_s, pop_s, multi_s;
    logic [1:0]    push_cmd_s, head_s;
    logic [10:0]   x_ext_s, x_dec_s, x_inc_s;
    logic [FW-1:0] frame_inc_s;

    // Frame tick: sync stage fall detect, registered so a v_sync fall yields a tick 3 clk later
    always_comb begin
        tick_d = vs_prev_q & ~vs_sync_q[1];
    end

    // Command queue: key edge detect, priority push, drop reporting, pop on tick
    always_comb begin
        edge_s     = {middle, left, right} & ~key_prev_q;
        push_req_s = |edge_s;
        multi_s    = (edge_s[2] & (edge_s[1] | edge_s[0])) | (edge_s[1] & edge_s[0]);
        pop_s      = tick_q && (count_q != {(AW + 1){1'b0}});
        head_s     = fifo_mem_q[rd_ptr_q];
        if (edge_s[2]) begin
            push_cmd_s = CMD_MIDDLE;
        end else if (edge_s[1]) begin
            push_cmd_s = CMD_LEFT;
        end else begin
            push_cmd_s = CMD_RIGHT;
        end
        // a full queue still accepts a push when the same cycle pops
        push_ok_s  = push_req_s && ((count_q != DEPTH_C) || pop_s);
        dropped_d  = multi_s || (push_req_s && !push_ok_s);
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok_s) begin
            fifo_mem_d[wr_ptr_q] = push_cmd_s;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
            count_d              = count_d + CNT_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - CNT_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        full_d = (count_d == DEPTH_C);
    end

    // Movement FSM: horizontal moves from popped commands, vertical jump sequencing
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        x_ext_s     = {1'b0, x_q};
        x_dec_s     = (x_ext_s < X_STEP_C) ? 11'd0 : (x_ext_s - X_STEP_C);
        x_inc_s     = ((x_ext_s + X_STEP_C) > X_LIM_C) ? X_LIM_C : (x_ext_s + X_STEP_C);
        frame_inc_s = frame_q + FR_ONE;

        if (pop_s) begin
            if (head_s == CMD_MIDDLE) begin
                // a jump request only starts from the ground; mid-jump it is discarded
                if (state_q == ST_IDLE) begin
                    state_d = ST_RISE;
                    busy_d  = 1'b1;
                    frame_d = {FW{1'b0}};
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                x_d   = (head_s == CMD_LEFT) ? x_dec_s[9:0] : x_inc_s[9:0];
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            x_d = x_q;
        end

        case (state_q)
            ST_IDLE: begin
                y_d = y_q;
            end
            ST_RISE: begin
                if (tick_q) begin
                    y_d     = y_q - Y_STEP_C;
                    frame_d = frame_inc_s;
                    if (frame_inc_s == JF_C) begin
                        state_d = ST_FALL;
                        frame_d = {FW{1'b0}};
                    end else begin
                        state_d = ST_RISE;
                    end
                end else begin
                    y_d = y_q;
                end
            end
            ST_FALL: begin
                if (tick_q) begin
                    y_d     = y_q + Y_STEP_C;
                    frame_d = frame_inc_s;
                    if (frame_inc_s == JF_C) begin
                        y_d     = Y_INIT_C;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                        frame_d = {FW{1'b0}};
                    end else begin
                        state_d = ST_FALL;
                    end
                end else begin
                    y_d = y_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                y_d     = Y_INIT_C;
                busy_d  = 1'b0;
                frame_d = {FW{1'b0}};
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_sync_q  <= 2'b11;
            vs_prev_q  <= 1'b1;
            tick_q     <= 1'b0;
            key_prev_q <= 3'b000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 2'd0;
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            state_q    <= ST_IDLE;
            frame_q    <= {FW{1'b0}};
            x_q        <= X_INIT_C;
            y_q        <= Y_INIT_C;
            cnt_q      <= 8'd0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            vs_sync_q  <= {vs_sync_q[0], v_sync};
            vs_prev_q  <= vs_sync_q[1];
            tick_q     <= tick_d;
            key_prev_q <= {middle, left, right};
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            dropped_q  <= dropped_d;
        end
    end

    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign counter   = cnt_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign dropped   = dropped_q;

endmodule
